mac_seq: RTL

Parametrised sequential unsigned multiplier-accumulator. It is the next generation after the fixed 2x2 combinational multiplier cell. The block computes an N x N product by iterative radix-2 shift-and-add, one partial product per clock. It then optionally adds the product into a wide accumulator register and signals completion with a start/done handshake. It forms the datapath core of the MAC unit.

---
 rtl/mac_seq_if.sv | 27 ++
 rtl/mac_seq.sv | 85 ++++++++
 2 files changed

// File: rtl/mac_seq_if.sv
// Handshake and data bundle for the sequential multiplier-accumulator.
// The master drives the request side; the slave (mac_seq) drives the results.
interface mac_seq_if #(
    parameter int N     = 8,
    parameter int ACC_W = 2*N+4
);
    logic               start;
    logic               acc_en;
    logic               clr_acc;
    logic [N-1:0]       a;
    logic [N-1:0]       b;
    logic               busy;
    logic               done;
    logic [2*N-1:0]     product;
    logic [ACC_W-1:0]   acc;
    logic               overflow;

    modport master (
        output start, acc_en, clr_acc, a, b,
        input  busy, done, product, acc, overflow
    );

    modport slave (
        input  start, acc_en, clr_acc, a, b,
        output busy, done, product, acc, overflow
    );
endinterface

// File: rtl/mac_seq.sv
// Sequential unsigned N x N shift-and-add multiplier with optional
// accumulation into a wide sticky-overflow accumulator.
module mac_seq #(
    parameter int N     = 8,
    parameter int ACC_W = 2*N+4
) (
    input  logic       clk,
    input  logic       rst,
    mac_seq_if.slave   bus
);
    localparam int CNT_W = $clog2(N);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MULT = 2'd1;
    localparam logic [1:0] ACC  = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] count;
    logic [N-1:0]     mcand;
    logic [N-1:0]     mplier;
    logic             acc_en_q;
    logic [2*N-1:0]   partial;
    logic [ACC_W-1:0] acc_base;
    logic [ACC_W:0]   acc_sum;

    assign bus.busy = (state == MULT) || (state == ACC);

    // A clear coincident with the ACC edge takes effect before the add.
    always_comb begin
        acc_base = bus.clr_acc ? '0 : bus.acc;
        acc_sum  = {1'b0, acc_base} + {{(ACC_W+1-2*N){1'b0}}, partial};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            count        <= '0;
            mcand        <= '0;
            mplier       <= '0;
            acc_en_q     <= 1'b0;
            partial      <= '0;
            bus.done     <= 1'b0;
            bus.product  <= '0;
            bus.acc      <= '0;
            bus.overflow <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            if (bus.clr_acc) begin
                bus.acc      <= '0;
                bus.overflow <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        mcand    <= bus.a;
                        mplier   <= bus.b;
                        acc_en_q <= bus.acc_en;
                        partial  <= '0;
                        count    <= '0;
                        state    <= MULT;
                    end
                end
                MULT: begin
                    if (mplier[0])
                        partial <= partial + ({{N{1'b0}}, mcand} << count);
                    mplier <= mplier >> 1;
                    count  <= count + CNT_W'(1);
                    if (count == CNT_W'(N-1))
                        state <= ACC;
                end
                ACC: begin
                    bus.product <= partial;
                    if (acc_en_q) begin
                        bus.acc <= acc_sum[ACC_W-1:0];
                        if (acc_sum[ACC_W])
                            bus.overflow <= 1'b1;
                    end
                    bus.done <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
